// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared types and constants for the ram_reader burst engine.
//   state_t    - burst FSM states (IDLE, RUN, DRAIN)
//   OBUF_DEPTH - entries in the output skid buffer
//   occ_t      - occupancy count type for that buffer (0..OBUF_DEPTH)
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned OBUF_DEPTH = 2;

  typedef logic [$clog2(OBUF_DEPTH+1)-1:0] occ_t;

endpackage

// File: rtl/ram_reader_obuf.sv
// ram_reader_obuf: two-entry valid/ready buffer carrying {last, data}.
// Ports:
//   clk, rstN            clock, async active-low reset
//   push/pushLast/pushData  word returning from the RAM (caller guarantees space)
//   outValid/outReady    stream handshake
//   outData/outLast      head entry; outLast is qualified by outValid
//   occupancy            entries currently held (0..2), fed to the issue logic
module ram_reader_obuf
  import ram_reader_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic             pushLast,
  input  logic [Width-1:0] pushData,
  output logic             outValid,
  input  logic             outReady,
  output logic [Width-1:0] outData,
  output logic             outLast,
  output occ_t             occupancy
);

  // ent0 is always the head; ent1 only holds a word while ent0 is full
  logic [Width:0] ent0;
  logic [Width:0] ent1;
  occ_t           occ;
  logic           pop;

  assign pop = (occ != '0) && outReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == '0) ent0 <= {pushLast, pushData};
          else           ent1 <= {pushLast, pushData};
          occ <= occ + occ_t'(1);
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - occ_t'(1);
        end
        2'b11: begin
          if (occ == occ_t'(1)) begin
            ent0 <= {pushLast, pushData};
          end else begin
            ent0 <= ent1;
            ent1 <= {pushLast, pushData};
          end
        end
        default: ;
      endcase
    end
  end

  assign outValid  = (occ != '0);
  assign outData   = ent0[Width-1:0];
  assign outLast   = outValid & ent0[Width];
  assign occupancy = occ;

endmodule

// File: rtl/ram_reader.sv
// ram_reader: burst read engine behind a one-cycle-latency RAM, presenting
// the words on a valid/ready stream with backpressure.
// Ports:
//   clk, rstN            clock, async active-low reset
//   start/baseAddr/length  burst request (sampled in IDLE only)
//   stride               address step (only with RAM_READER_STRIDE_EN defined)
//   busy, done           burst in progress / one-cycle end pulse
//   rdAddr, rdData       RAM read port
//   outValid/outReady/outData/outLast  output stream
// Build option: define RAM_READER_STRIDE_EN to add the stride input; otherwise
// the address step is fixed at 1.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 1024
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic [$clog2(Depth)-1:0] baseAddr,
  input  logic [$clog2(Depth):0]   length,
`ifdef RAM_READER_STRIDE_EN
  input  logic [$clog2(Depth)-1:0] stride,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(Depth)-1:0] rdAddr,
  input  logic [Width-1:0]         rdData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [Width-1:0]         outData,
  output logic                     outLast
);

  localparam int unsigned AW  = $clog2(Depth);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t        state, stateNext;
  logic [AW-1:0] addr;
  logic [AW-1:0] step;
  logic [AW:0]   remaining;
  logic          inflight;
  logic          inflightLast;
  occ_t          occ;
  logic          pop;
  logic          issue;
  logic [2:0]    slots;
  logic          accept;

  assign accept = (state == IDLE) && start;
  assign pop    = outValid & outReady;

  // Buffer plus in-flight must stay within two once this cycle's pop retires.
  assign slots = 3'(occ) + 3'(inflight);
  assign issue = (state == RUN) && (remaining != '0) &&
                 (slots < (pop ? 3'd3 : 3'd2));

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start && (length != '0)) stateNext = RUN;
      RUN:     if (issue && (remaining == ONE)) stateNext = DRAIN;
      DRAIN:   if (pop && outLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      inflight     <= 1'b0;
      inflightLast <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= stateNext;
      inflight     <= issue;
      inflightLast <= issue && (remaining == ONE);
      done         <= (accept && (length == '0)) ||
                      ((state == DRAIN) && pop && outLast);
      if (accept) begin
        addr      <= baseAddr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr + step;
        remaining <= remaining - ONE;
      end
    end
  end

`ifdef RAM_READER_STRIDE_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)       step <= '0;
    else if (accept) step <= stride;
  end
`else
  assign step = AW'(1);
`endif

  assign busy   = (state != IDLE);
  assign rdAddr = addr;

  ram_reader_obuf #(
    .Width (Width)
  ) u_obuf (
    .clk       (clk),
    .rstN      (rstN),
    .push      (inflight),
    .pushLast  (inflightLast),
    .pushData  (rdData),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData   (outData),
    .outLast   (outLast),
    .occupancy (occ)
  );

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: bench for ram_reader with a behavioural RAM (mem[k]=k) and a
// queue-based expected stream computed from base/length/stride.
module tb_ram_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 1024;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [AW:0]   length = '0;
`ifdef RAM_READER_STRIDE_EN
  logic [AW-1:0] stride = '0;
`endif
  logic          busy, done, outValid, outLast;
  logic          outReady = 1'b0;
  logic [AW-1:0] rdAddr;
  logic [W-1:0]  rdData;
  logic [W-1:0]  outData;

  logic [W-1:0]  ram [D];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdData <= ram[rdAddr];

  ram_reader #(
    .Width (W),
    .Depth (D)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .start    (start),
    .baseAddr (baseAddr),
    .length   (length),
`ifdef RAM_READER_STRIDE_EN
    .stride   (stride),
`endif
    .busy     (busy),
    .done     (done),
    .rdAddr   (rdAddr),
    .rdData   (rdData),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outLast  (outLast)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned base;
    int unsigned len;
    int unsigned pct;
    int unsigned strd;
    int unsigned firstW;
    int unsigned lastW;
    bit          poke;
  } vec_t;

  task automatic run_burst(input vec_t v);
    logic [W-1:0] expq[$];
    int unsigned  got = 0;
    int           n = 0;
    int           budget;
    bit           finished = 0;
    logic         prevV = 1'b0, prevR = 1'b0, prevL = 1'b0;
    logic [W-1:0] prevD = '0;
    for (int unsigned i = 0; i < v.len; i++)
      expq.push_back(ram[(v.base + i * v.strd) % D]);
    budget   = int'(v.len) * 20 + 50;
    baseAddr = AW'(v.base);
    length   = (AW+1)'(v.len);
`ifdef RAM_READER_STRIDE_EN
    stride   = AW'(v.strd);
`endif
    start    = 1'b1;
    outReady = (v.pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < v.pct);
    @(posedge clk);
    #1 start = 1'b0;
    while (!finished && n < budget) begin
      @(negedge clk);
      if (v.poke && n == 3) begin
        start = 1'b1; baseAddr = 900; length = 3;
      end else if (v.poke && n == 4) begin
        start = 1'b0;
      end
      outReady = (v.pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < v.pct);
      if (n == 0) begin
        chk("busy_after_start", busy, 1);
        chk("rdaddr_after_start", rdAddr, v.base);
      end
      chk("done_early", done, 0);
      if (prevV && !prevR) begin
        chk("stall_valid_held", outValid, 1);
        chk("stall_data_stable", outData, prevD);
        chk("stall_last_stable", outLast, prevL);
      end
      if (v.pct >= 100) chk("valid_timing", outValid, (n >= 2));
      if (outValid && outReady) begin
        chk("word_data", outData, expq[got]);
        chk("word_last", outLast, (got == v.len - 1));
        if (got == 0) begin
          chk("first_word", outData, v.firstW);
          if (v.pct >= 100) chk("first_latency", n, 2);
        end
        if (got == v.len - 1) begin
          chk("last_word", outData, v.lastW);
          finished = 1;
        end
        got++;
      end
      prevV = outValid; prevR = outReady; prevD = outData; prevL = outLast;
      n++;
    end
    if (!finished) begin
      checks++; failures++;
      $display("FAIL burst_timeout base=%0d got=%0d required=%0d", v.base, got, v.len);
      start = 1'b0;
    end else begin
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      chk("valid_end", outValid, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      @(negedge clk);
      chk("no_extra_burst_busy", busy, 0);
      chk("no_extra_burst_done", done, 0);
    end
    outReady = 1'b1;
  endtask

  initial begin
    vec_t tbl[$];
    int   hs;

    for (int k = 0; k < int'(D); k++) ram[k] = W'(k);

    // reset state
    #1 rstN = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_last", outLast, 0);
    chk("rst_data", outData, 0);
    chk("rst_rdaddr", rdAddr, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    tbl.push_back('{10,   4,    100, 1, 10,   13,   0});
    tbl.push_back('{1022, 4,    100, 1, 1022, 1,    0});
    tbl.push_back('{200,  64,   50,  1, 200,  263,  0});
    tbl.push_back('{100,  8,    100, 1, 100,  107,  1});
    tbl.push_back('{5,    1,    100, 1, 5,    5,    0});
    tbl.push_back('{1023, 2,    30,  1, 1023, 0,    0});
    tbl.push_back('{0,    1024, 100, 1, 0,    1023, 0});
`ifdef RAM_READER_STRIDE_EN
    tbl.push_back('{1020, 3,    100, 3, 1020, 2,    0});
    tbl.push_back('{7,    3,    60,  0, 7,    7,    0});
`endif
    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.base = $urandom_range(0, D - 1);
      v.len  = $urandom_range(1, 40);
      v.pct  = $urandom_range(20, 100);
`ifdef RAM_READER_STRIDE_EN
      v.strd = $urandom_range(0, D - 1);
`else
      v.strd = 1;
`endif
      v.firstW = v.base;
      v.lastW  = (v.base + (v.len - 1) * v.strd) % D;
      v.poke   = 0;
      tbl.push_back(v);
    end

    foreach (tbl[i]) run_burst(tbl[i]);

    // zero-length request
    @(negedge clk);
    baseAddr = 33; length = 0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", outValid, 0);
    @(negedge clk);
    chk("len0_done_drop", done, 0);
    chk("len0_busy_after", busy, 0);
    chk("len0_valid_after", outValid, 0);

    // asynchronous reset mid-burst, after the third word
    baseAddr = 300; length = 16; start = 1'b1; outReady = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hs = 0;
    for (int c = 0; c < 30 && hs < 3; c++) begin
      @(negedge clk);
      if (outValid && outReady) hs++;
    end
    chk("pre_reset_words", hs, 3);
    #2 rstN = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", outValid, 0);
    chk("abort_last", outLast, 0);
    chk("abort_data", outData, 0);
    chk("abort_rdaddr", rdAddr, 0);
    @(negedge clk);
    chk("abort_hold_valid", outValid, 0);
    rstN = 1'b1;
    @(negedge clk);
    run_burst('{40, 5, 100, 1, 40, 44, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
